// File: rtl/shifter_pipe_if.sv
// Valid/ready operand and result bus for the pipelined barrel shifter.
// The shifter takes the slave view; the environment takes the master view.
interface shifter_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
);
    localparam int unsigned S = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [S-1:0]     in_shamt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready on both sides and a
// sideband tag; REG_EVERY mux levels sit between consecutive pipeline registers.
module shifter_pipe #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned REG_EVERY = 1,
    parameter int unsigned TAG_W     = 5
) (
    input  logic          clock,
    input  logic          reset,
    shifter_pipe_if.slave bus
);
    localparam int unsigned S   = $clog2(WIDTH);
    localparam int unsigned NST = (S + REG_EVERY - 1) / REG_EVERY;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    // Index 0 is the input port; index s+1 is the register bank of stage s.
    logic             w_adv;
    logic             w_vld   [0:NST];
    logic [WIDTH-1:0] w_data  [0:NST];
    logic [TAG_W-1:0] w_tag   [0:NST];
    logic [1:0]       w_op    [0:NST-1];
    logic             w_sgn   [0:NST-1];
    logic [S-1:0]     w_shamt [0:NST-1];

    // One mux level: shift by a fixed power of two in the selected mode.
    function automatic logic [WIDTH-1:0] f_level(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input logic             sgn,
        input int unsigned      amt
    );
        logic [WIDTH-1:0] r;
        r = d;
        case (op)
            OP_SLL:  r = d << amt;
            OP_SRL:  r = d >> amt;
            OP_SRA:  r = (d >> amt) | (sgn ? ~({WIDTH{1'b1}} >> amt) : '0);
            default: r = (d << amt) | (d >> (WIDTH - amt));
        endcase
        return r;
    endfunction

    // The whole pipe advances together; a stalled output freezes every stage.
    assign w_adv        = !w_vld[NST] || bus.out_ready;
    assign bus.in_ready = w_adv;

    assign w_vld[0]   = bus.in_valid;
    assign w_data[0]  = bus.in_data;
    assign w_tag[0]   = bus.in_tag;
    assign w_op[0]    = bus.in_op;
    assign w_sgn[0]   = bus.in_data[WIDTH-1];
    assign w_shamt[0] = bus.in_shamt;

    assign bus.out_valid = w_vld[NST];
    assign bus.out_data  = w_data[NST];
    assign bus.out_tag   = w_tag[NST];

    for (genvar s = 0; s < NST; s++) begin : g_stage
        localparam int unsigned LO = s * REG_EVERY;
        localparam int unsigned HI = ((s + 1) * REG_EVERY < S) ? (s + 1) * REG_EVERY : S;

        logic [WIDTH-1:0] w_mux;
        logic [S-1:0]     w_bits;
        logic             r_vld;
        logic [WIDTH-1:0] r_data;
        logic [TAG_W-1:0] r_tag;

        // Mux levels LO..HI-1, each consuming one shamt bit.
        always_comb begin
            w_mux  = w_data[s];
            w_bits = w_shamt[s] >> LO;
            for (int unsigned k = LO; k < HI; k++) begin
                if (w_bits[0]) begin
                    w_mux = f_level(w_mux, w_op[s], w_sgn[s], 32'd1 << k);
                end
                w_bits = w_bits >> 1;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                r_vld  <= 1'b0;
                r_data <= '0;
                r_tag  <= '0;
            end else if (w_adv) begin
                r_vld  <= w_vld[s];
                r_data <= w_mux;
                r_tag  <= w_tag[s];
            end
        end

        assign w_vld[s+1]  = r_vld;
        assign w_data[s+1] = r_data;
        assign w_tag[s+1]  = r_tag;

        // Control sideband only travels as far as the last mux level needs it.
        if (s < NST - 1) begin : g_ctl
            logic [1:0]   r_op;
            logic         r_sgn;
            logic [S-1:0] r_shamt;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_op    <= '0;
                    r_sgn   <= 1'b0;
                    r_shamt <= '0;
                end else if (w_adv) begin
                    r_op    <= w_op[s];
                    r_sgn   <= w_sgn[s];
                    r_shamt <= w_shamt[s];
                end
            end

            assign w_op[s+1]    = r_op;
            assign w_sgn[s+1]   = r_sgn;
            assign w_shamt[s+1] = r_shamt;
        end
    end
endmodule

// File: tb/tb_shifter_pipe.sv
// Directed and randomised checks of shifter_pipe across four parameter sets.
module tb_shifter_pipe;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        int          sh;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        n_rst;
    logic [3:0]  t_iv, t_ordy, n_iv, n_ordy;
    logic [31:0] t_id [4];
    logic [4:0]  t_sh [4];
    logic [1:0]  t_op [4];
    logic [4:0]  t_tag [4];
    logic [31:0] n_id [4];
    logic [4:0]  n_sh [4];
    logic [1:0]  n_op [4];
    logic [4:0]  n_tag [4];
    logic [31:0] n_exp [4];
    wire  [3:0]  t_ir, t_ov;
    wire  [31:0] t_od [4];
    wire  [4:0]  t_ot [4];

    logic [31:0] sb_d [4][256];
    logic [4:0]  sb_t [4][256];
    int          wr [4];
    int          rd [4];
    int          total = 0;
    int          bad   = 0;
    vec_t        vec [15];

    always #5 clk = ~clk;

    // dut 0: 32/RE1, dut 1: 32/RE2, dut 2: 32/RE5, dut 3: 8/RE3
    shifter_pipe_if #(.WIDTH(32), .TAG_W(5)) if_a ();
    shifter_pipe_if #(.WIDTH(32), .TAG_W(5)) if_b ();
    shifter_pipe_if #(.WIDTH(32), .TAG_W(5)) if_c ();
    shifter_pipe_if #(.WIDTH(8),  .TAG_W(5)) if_d ();

    shifter_pipe #(.WIDTH(32), .REG_EVERY(1), .TAG_W(5)) u_a (.clock(clk), .reset(rst), .bus(if_a.slave));
    shifter_pipe #(.WIDTH(32), .REG_EVERY(2), .TAG_W(5)) u_b (.clock(clk), .reset(rst), .bus(if_b.slave));
    shifter_pipe #(.WIDTH(32), .REG_EVERY(5), .TAG_W(5)) u_c (.clock(clk), .reset(rst), .bus(if_c.slave));
    shifter_pipe #(.WIDTH(8),  .REG_EVERY(3), .TAG_W(5)) u_d (.clock(clk), .reset(rst), .bus(if_d.slave));

    assign if_a.in_valid = t_iv[0];  assign if_a.in_data = t_id[0];  assign if_a.in_shamt = t_sh[0];
    assign if_a.in_op = t_op[0];     assign if_a.in_tag = t_tag[0];  assign if_a.out_ready = t_ordy[0];
    assign t_ir[0] = if_a.in_ready;  assign t_ov[0] = if_a.out_valid;
    assign t_od[0] = if_a.out_data;  assign t_ot[0] = if_a.out_tag;

    assign if_b.in_valid = t_iv[1];  assign if_b.in_data = t_id[1];  assign if_b.in_shamt = t_sh[1];
    assign if_b.in_op = t_op[1];     assign if_b.in_tag = t_tag[1];  assign if_b.out_ready = t_ordy[1];
    assign t_ir[1] = if_b.in_ready;  assign t_ov[1] = if_b.out_valid;
    assign t_od[1] = if_b.out_data;  assign t_ot[1] = if_b.out_tag;

    assign if_c.in_valid = t_iv[2];  assign if_c.in_data = t_id[2];  assign if_c.in_shamt = t_sh[2];
    assign if_c.in_op = t_op[2];     assign if_c.in_tag = t_tag[2];  assign if_c.out_ready = t_ordy[2];
    assign t_ir[2] = if_c.in_ready;  assign t_ov[2] = if_c.out_valid;
    assign t_od[2] = if_c.out_data;  assign t_ot[2] = if_c.out_tag;

    assign if_d.in_valid = t_iv[3];  assign if_d.in_data = t_id[3][7:0];  assign if_d.in_shamt = t_sh[3][2:0];
    assign if_d.in_op = t_op[3];     assign if_d.in_tag = t_tag[3];       assign if_d.out_ready = t_ordy[3];
    assign t_ir[3] = if_d.in_ready;  assign t_ov[3] = if_d.out_valid;
    assign t_od[3] = {24'h0, if_d.out_data};  assign t_ot[3] = if_d.out_tag;

    // Bit-by-bit reference, independent of the mux-level decomposition.
    function automatic logic [31:0] ref_sh(input logic [31:0] d, input int sh, input logic [1:0] op, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (op)
                2'b00:   r[i] = (i >= sh) ? d[i-sh] : 1'b0;
                2'b01:   r[i] = (i + sh < w) ? d[i+sh] : 1'b0;
                2'b10:   r[i] = (i + sh < w) ? d[i+sh] : d[w-1];
                default: r[i] = d[(i - sh + w) % w];
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        n_rst  = 1'b0;
        n_iv   = 4'b0000;
        n_ordy = 4'b1111;
    endtask

    task automatic stage(input int d, input logic [1:0] op, input logic [31:0] data, input int sh,
                         input logic [4:0] tag, input logic [31:0] exp);
        n_iv[d]  = 1'b1;
        n_op[d]  = op;
        n_id[d]  = data;
        n_sh[d]  = 5'(sh);
        n_tag[d] = tag;
        n_exp[d] = exp;
    endtask

    // One clock cycle: drive at negedge, then score outputs and log acceptances.
    task automatic tick();
        @(negedge clk);
        rst = n_rst;
        for (int d = 0; d < 4; d++) begin
            t_iv[d] = n_iv[d]; t_id[d] = n_id[d]; t_sh[d] = n_sh[d];
            t_op[d] = n_op[d]; t_tag[d] = n_tag[d]; t_ordy[d] = n_ordy[d];
        end
        #1;
        for (int d = 0; d < 4; d++) begin
            if (!rst && t_ov[d] && t_ordy[d]) begin
                if (rd[d] == wr[d]) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out dut%0d: got data=%h tag=%h, expected no result", d, t_od[d], t_ot[d]);
                end else begin
                    check($sformatf("out_data dut%0d #%0d", d, rd[d]), t_od[d], sb_d[d][rd[d] % 256]);
                    check($sformatf("out_tag dut%0d #%0d", d, rd[d]), 32'(t_ot[d]), 32'(sb_t[d][rd[d] % 256]));
                    rd[d]++;
                end
            end
            if (!rst && t_iv[d] && t_ir[d]) begin
                sb_d[d][wr[d] % 256] = n_exp[d];
                sb_t[d][wr[d] % 256] = n_tag[d];
                wr[d]++;
            end
            if (rst) rd[d] = wr[d];
        end
    endtask

    initial begin
        int base [3];
        int k;
        logic [31:0] dat;

        vec[0]  = '{2'b00, 32'h0000_0001, 31, 32'h8000_0000};
        vec[1]  = '{2'b10, 32'h8000_0000, 4,  32'hF800_0000};
        vec[2]  = '{2'b01, 32'h8000_0000, 4,  32'h0800_0000};
        vec[3]  = '{2'b11, 32'h8000_0001, 1,  32'h0000_0003};
        vec[4]  = '{2'b00, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF};
        vec[5]  = '{2'b01, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF};
        vec[6]  = '{2'b10, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF};
        vec[7]  = '{2'b11, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF};
        vec[8]  = '{2'b10, 32'h7FFF_FFFF, 31, 32'h0000_0000};
        vec[9]  = '{2'b10, 32'h8000_0000, 31, 32'hFFFF_FFFF};
        vec[10] = '{2'b11, 32'h1234_5678, 8,  32'h3456_7812};
        vec[11] = '{2'b11, 32'h1234_5678, 31, 32'h091A_2B3C};
        vec[12] = '{2'b00, 32'hFFFF_FFFF, 16, 32'hFFFF_0000};
        vec[13] = '{2'b01, 32'hFFFF_FFFF, 31, 32'h0000_0001};
        vec[14] = '{2'b00, 32'h0000_ABCD, 5,  32'h0015_79A0};

        for (int d = 0; d < 4; d++) begin
            wr[d] = 0; rd[d] = 0;
            t_id[d] = '0; t_sh[d] = '0; t_op[d] = '0; t_tag[d] = '0;
            n_id[d] = '0; n_sh[d] = '0; n_op[d] = '0; n_tag[d] = '0; n_exp[d] = '0;
        end
        t_iv = '0; t_ordy = '1;
        idle();
        n_rst = 1'b1;
        tick(); tick();
        idle();

        // Reset state and single-op latency (LAT=5)
        stage(0, 2'b00, 32'h1, 31, 5'd7, 32'h8000_0000);
        tick();
        check("rst out_valid", 32'(t_ov[0]), 32'd0);
        check("rst out_data", t_od[0], 32'd0);
        check("rst out_tag", 32'(t_ot[0]), 32'd0);
        check("rst in_ready", 32'(t_ir[0]), 32'd1);
        check("rst out_valid dut1", 32'(t_ov[1]), 32'd0);
        idle();
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("lat out_valid c%0d", c), 32'(t_ov[0]), 32'd0);
        end
        tick();
        check("lat out_valid c5", 32'(t_ov[0]), 32'd1);
        check("lat out_data c5", t_od[0], 32'h8000_0000);
        check("lat out_tag c5", 32'(t_ot[0]), 32'd7);

        // Table vectors back-to-back; results must emerge on consecutive cycles
        for (int j = 0; j < 15 + 5; j++) begin
            idle();
            if (j < 15) stage(0, vec[j].op, vec[j].data, vec[j].sh, 5'(j), vec[j].exp);
            tick();
            if (j >= 5) check($sformatf("b2b out_valid j%0d", j), 32'(t_ov[0]), 32'd1);
        end
        idle();
        tick();

        // Output stall for cycles 6..9 while streaming 8 ops
        base[0] = wr[0];
        for (int j = 0; j < 30; j++) begin
            idle();
            k = wr[0] - base[0];
            if (k < 8) begin
                dat = 32'h8421_0F0F ^ (32'h0101_0101 * 32'(k));
                stage(0, 2'(k), dat, (3 * k + 1) % 32, 5'(16 + k), ref_sh(dat, (3 * k + 1) % 32, 2'(k), 32));
            end
            n_ordy[0] = !(j >= 6 && j <= 9);
            tick();
            if (j >= 6 && j <= 9) begin
                check($sformatf("stall in_ready j%0d", j), 32'(t_ir[0]), 32'd0);
                check($sformatf("stall out_valid j%0d", j), 32'(t_ov[0]), 32'd1);
                check($sformatf("stall held data j%0d", j), t_od[0], sb_d[0][rd[0] % 256]);
                check($sformatf("stall held tag j%0d", j), 32'(t_ot[0]), 32'(sb_t[0][rd[0] % 256]));
            end
        end
        check("stall accepted count", 32'(wr[0] - base[0]), 32'd8);
        check("stall drained", 32'(wr[0] - rd[0]), 32'd0);

        // Mid-flight reset, nothing new offered
        idle();
        stage(0, 2'b00, 32'h3, 1, 5'd1, 32'h6); tick();
        stage(0, 2'b01, 32'h30, 4, 5'd2, 32'h3); tick();
        stage(0, 2'b11, 32'h1, 3, 5'd3, 32'h8); n_rst = 1'b1; tick();
        idle();
        for (int j = 3; j <= 10; j++) begin
            tick();
            if (j == 3) check("post-rst in_ready", 32'(t_ir[0]), 32'd1);
            check($sformatf("post-rst out_valid j%0d", j), 32'(t_ov[0]), 32'd0);
        end

        // Mid-flight reset, new op accepted right after release
        stage(0, 2'b00, 32'h3, 1, 5'd1, 32'h6); tick();
        stage(0, 2'b01, 32'h30, 4, 5'd2, 32'h3); tick();
        stage(0, 2'b11, 32'h1, 3, 5'd3, 32'h8); n_rst = 1'b1; tick();
        idle();
        for (int j = 3; j <= 8; j++) begin
            idle();
            if (j == 3) stage(0, 2'b01, 32'hF000_0000, 8, 5'h15, 32'h00F0_0000);
            tick();
            if (j < 8) check($sformatf("rst-new out_valid j%0d", j), 32'(t_ov[0]), 32'd0);
        end
        check("rst-new out_valid j8", 32'(t_ov[0]), 32'd1);
        check("rst-new out_data j8", t_od[0], 32'h00F0_0000);
        check("rst-new out_tag j8", 32'(t_ot[0]), 32'h15);
        idle();
        tick();

        // 8-bit, one register (LAT=1)
        stage(3, 2'b10, 32'h90, 3, 5'd9, 32'hF2); tick();
        idle();
        stage(3, 2'b11, 32'h81, 7, 5'd10, 32'hC0); tick();
        check("w8 sra out_valid", 32'(t_ov[3]), 32'd1);
        check("w8 sra out_data", t_od[3], 32'hF2);
        idle(); tick();
        check("w8 rol out_valid", 32'(t_ov[3]), 32'd1);
        check("w8 rol out_data", t_od[3], 32'hC0);
        idle(); tick();

        // Random handshake sweep of every op/shamt pair on the 32-bit variants
        for (int d = 0; d < 3; d++) base[d] = wr[d];
        for (int c = 0; c < 1000; c++) begin
            idle();
            for (int d = 0; d < 3; d++) begin
                k   = wr[d] - base[d];
                dat = $urandom;
                n_iv[d]   = ($urandom_range(0, 3) != 0);
                n_op[d]   = 2'(k);
                n_sh[d]   = 5'(k >> 2);
                n_id[d]   = dat;
                n_tag[d]  = 5'(k);
                n_exp[d]  = ref_sh(dat, (k >> 2) % 32, 2'(k), 32);
                n_ordy[d] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        idle();
        for (int c = 0; c < 20; c++) tick();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rand drained dut%0d", d), 32'(wr[d] - rd[d]), 32'd0);
            check($sformatf("rand sweep covered dut%0d", d), 32'(wr[d] - base[d] >= 128), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter. Successor to the fixed 32-bit combinational SLL.
- Supports four modes: logical left, logical right, arithmetic right, rotate left.
- Sits between the ALU operand stage and the writeback mux. Uses valid/ready handshakes on both sides and carries a sideband tag (e.g. destination register) alongside the data.
- Latency is set by a parameter, so it can be traded against clock frequency.

Parameters:
- WIDTH, 32, data width. Must be a power of 2 and at least 2. Shift-amount width S = log2(WIDTH) is a derived localparam.
- REG_EVERY, 1, number of mux levels between pipeline registers. Range 1..S.
- TAG_W, 5, width of the sideband tag carried with each operation.

Ports:
- clock, input, 1, single clock; rising edge.
- reset, input, 1, synchronous, active-high.
- in_valid, input, 1, operation offered.
- in_ready, output, 1, block accepts the operation this cycle.
- in_data, input, WIDTH, operand.
- in_shamt, input, S, shift amount 0..WIDTH-1.
- in_op, input, 2, mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- in_tag, input, TAG_W, sideband; passed through unchanged.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer takes the result.
- out_data, output, WIDTH, shifted result.
- out_tag, output, TAG_W, tag of the operation in out_data.

Behaviour:
- Datapath structure:
  - S mux levels. Level k applies a shift of 2^k when in_shamt[k]=1.
  - A pipeline register follows level k when (k+1) % REG_EVERY == 0, or when k = S-1. The final register drives the outputs.
  - Latency LAT = ceil(S/REG_EVERY) cycles from the accepting edge to out_valid. Example: WIDTH=32, REG_EVERY=1 gives LAT=5.
- Per-stage contents: op, the remaining shamt bits, tag, and a valid bit all travel with the data in every stage.
- Fill rules per mode:
  - SLL: shift left, zero fill at the LSB end.
  - SRL: shift right, zero fill at the MSB end.
  - SRA: shift right, fill with the original in_data[WIDTH-1]. The sign bit is carried per stage.
  - ROL: bits shifted out of the MSB re-enter at the LSB.
- shamt = 0: out_data = in_data in every mode.
- Handshake:
  - Global advance enable adv = !out_valid || out_ready. in_ready = adv (combinational).
  - A transfer occurs when in_valid && in_ready. Stage 0 loads the operation with its valid bit set to 1.
  - When adv=1 and in_valid=0, a bubble with valid=0 enters stage 0.
  - When adv=0, every stage holds. out_data and out_tag stay stable while out_valid && !out_ready.
  - Bubbles are not collapsed, and throughput is one operation per cycle while out_ready=1.
  - Results leave in acceptance order. None are dropped or duplicated.
  - in_data, in_shamt, in_op and in_tag are sampled only at the accepting edge. Changes at other times have no effect.
- Reset (synchronous):
  - out_valid=0, all stage valid bits=0, out_data=0, out_tag=0.
  - Internal data registers clear to 0.
  - in_ready=1 in the first cycle after reset is released.
  - Reset asserted mid-operation discards all in-flight operations; none appear at the output afterwards.
  - An operation presented in the same cycle that reset is high is not accepted.
- No X propagation: out_data is only meaningful when out_valid=1, but it must always be driven from a register.

Test Plan:
1. WIDTH=32, REG_EVERY=1. Accept SLL, in_data=0x00000001, shamt=31, tag=7 at cycle 0, out_ready=1 -> out_valid=1 at cycle 5 with out_data=0x80000000, out_tag=7. out_valid=0 at cycles 1-4.
2. Back-to-back SRA 0x80000000>>4, SRL 0x80000000>>4, ROL 0x80000001 by 1, SLL 0xDEADBEEF by 0 -> outputs on consecutive cycles: 0xF8000000, 0x08000000, 0x00000003, 0xDEADBEEF.
3. Stream 8 operations with out_ready=0 for cycles 6-9 -> in_ready=0 for those cycles. out_data/out_tag held constant. All 8 results emerge in order, none lost or duplicated.
4. Accept 3 operations, assert reset at cycle 2 for one cycle -> out_valid stays 0 through cycle 10. in_ready=1 at cycle 3. A new operation accepted at cycle 3 appears at cycle 8.
5. WIDTH=8, REG_EVERY=3 (LAT=1). SRA 0x90>>3 -> 0xF2 one cycle after acceptance; ROL 0x81 by 7 -> 0xC0.
6. Randomised sweep of all op and shamt values for WIDTH=32 with REG_EVERY in {1,2,5}, random in_valid/out_ready -> every result matches the reference model; order and count preserved.
